// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode packet handshake bundle for fetch_queue
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_instr;
  logic [31:0] enq_pc;
  logic [31:0] enq_pcp4;
  logic        enq_bp;
  logic [31:0] enq_btarget;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic [31:0] deq_pcp4;
  logic        deq_bp;
  logic [31:0] deq_btarget;
  logic [AW:0] count;

  modport master (
    output flush, enq_valid, enq_instr, enq_pc, enq_pcp4, enq_bp, enq_btarget, deq_ready,
    input  enq_ready, deq_valid, deq_instr, deq_pc, deq_pcp4, deq_bp, deq_btarget, count
  );

  modport slave (
    input  flush, enq_valid, enq_instr, enq_pc, enq_pcp4, enq_bp, enq_btarget, deq_ready,
    output enq_ready, deq_valid, deq_instr, deq_pc, deq_pcp4, deq_bp, deq_btarget, count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode decoupling FIFO with single-cycle mispredict flush
// Optional same-cycle empty-queue bypass enabled by FETCH_QUEUE_BYPASS_EN
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  fetch_queue_if.slave bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [31:0] NOP  = 32'h00000033;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        bp;
    logic [31:0] btarget;
  } pkt_t;

  pkt_t          mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count_q;

  pkt_t enq_pkt;
  pkt_t out_pkt;
  logic empty;
  logic bypass;
  logic enq_fire;
  logic deq_fire;
  logic wr_en;
  logic rd_en;

  always_comb begin
    enq_pkt.instr   = bus.enq_instr;
    enq_pkt.pc      = bus.enq_pc;
    enq_pkt.pcp4    = bus.enq_pcp4;
    enq_pkt.bp      = bus.enq_bp;
    enq_pkt.btarget = bus.enq_btarget;

    empty         = (count_q == '0);
    bus.enq_ready = (count_q != FULL);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = empty & bus.enq_valid & ~bus.flush;
`else
    bypass = 1'b0;
`endif
    bus.deq_valid = ~empty | bypass;

    out_pkt = bypass ? enq_pkt : mem[head];
    if (!bus.deq_valid) begin
      out_pkt.instr   = NOP;
      out_pkt.pc      = '0;
      out_pkt.pcp4    = '0;
      out_pkt.bp      = 1'b0;
      out_pkt.btarget = '0;
    end
    bus.deq_instr   = out_pkt.instr;
    bus.deq_pc      = out_pkt.pc;
    bus.deq_pcp4    = out_pkt.pcp4;
    bus.deq_bp      = out_pkt.bp;
    bus.deq_btarget = out_pkt.btarget;
    bus.count       = count_q;

    // A bypassed packet consumed in the same cycle never touches storage.
    enq_fire = bus.enq_valid & bus.enq_ready;
    deq_fire = bus.deq_valid & bus.deq_ready;
    wr_en    = enq_fire & ~(bypass & bus.deq_ready) & ~bus.flush;
    rd_en    = deq_fire & ~bypass & ~bus.flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) tail <= tail + AW'(1);
      if (rd_en) head <= head + AW'(1);
      count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[tail] <= enq_pkt;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000033;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        bp;
    logic [31:0] btarget;
  } pkt_t;

  pkt_t model[$];

  typedef struct {
    logic        r, fl, ev;
    logic [31:0] instr, pc;
    logic        dr, chk, dv;
    logic [31:0] epc, einstr;
    int          cnt;
    logic        er;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic fl, input logic ev,
                       input logic [31:0] instr, input logic [31:0] pc, input logic dr);
    @(negedge clk);
    rst_n           = r;
    bus.flush       = fl;
    bus.enq_valid   = ev;
    bus.enq_instr   = instr;
    bus.enq_pc      = pc;
    bus.enq_pcp4    = pc + 32'd4;
    bus.enq_bp      = pc[2];
    bus.enq_btarget = pc ^ 32'h8000_0000;
    bus.deq_ready   = dr;
    #1;
  endtask

  function automatic logic bypass_now();
`ifdef FETCH_QUEUE_BYPASS_EN
    return (model.size() == 0) && bus.enq_valid && !bus.flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic pkt_t enq_pkt();
    pkt_t p;
    p.instr   = bus.enq_instr;
    p.pc      = bus.enq_pc;
    p.pcp4    = bus.enq_pcp4;
    p.bp      = bus.enq_bp;
    p.btarget = bus.enq_btarget;
    return p;
  endfunction

  // Reference model: a plain queue advanced on each rising edge from the inputs.
  always @(posedge clk) begin
    if (rst_n !== 1'b1 || bus.flush === 1'b1) begin
      model.delete();
    end else if (bypass_now() && bus.deq_ready) begin
    end else begin
      automatic int  sz = model.size();
      automatic logic ef = bus.enq_valid && (sz < DEPTH);
      if (sz > 0 && bus.deq_ready) void'(model.pop_front());
      if (ef) model.push_back(enq_pkt());
    end
  end

  task automatic check_model();
    pkt_t e;
    logic dv;
    dv = 1'b1;
    if (bypass_now()) e = enq_pkt();
    else if (model.size() > 0) e = model[0];
    else begin
      dv = 1'b0;
      e = '{NOP, 32'd0, 32'd0, 1'b0, 32'd0};
    end
    check("rnd_deq_valid", bus.deq_valid, dv);
    check("rnd_deq_instr", bus.deq_instr, e.instr);
    check("rnd_deq_pc", bus.deq_pc, e.pc);
    check("rnd_deq_pcp4", bus.deq_pcp4, e.pcp4);
    check("rnd_deq_bp", bus.deq_bp, e.bp);
    check("rnd_deq_btarget", bus.deq_btarget, e.btarget);
    check("rnd_count", bus.count, model.size());
    check("rnd_enq_ready", bus.enq_ready, model.size() < DEPTH);
  endtask

  initial begin
    vec_t tbl[21];
    rst_n = 1'b0; bus.flush = 1'b0; bus.enq_valid = 1'b0; bus.deq_ready = 1'b0;
    bus.enq_instr = '0; bus.enq_pc = '0; bus.enq_pcp4 = '0; bus.enq_bp = 1'b0; bus.enq_btarget = '0;

    // r fl ev instr pc dr | chk dv epc einstr cnt er
    tbl = '{
      '{0,0,0,32'h0,32'h0,0,        0,0,32'h0,NOP,0,1},
      '{0,0,0,32'h0,32'h0,0,        1,0,32'h0,NOP,0,1},
      '{1,0,0,32'h0,32'h0,0,        1,0,32'h0,NOP,0,1},
      '{1,0,1,32'h00500093,32'h100,1, 1,0,32'h0,NOP,0,1},
      '{1,0,0,32'h0,32'h0,1,        1,1,32'h100,32'h00500093,1,1},
      '{1,0,0,32'h0,32'h0,0,        1,0,32'h0,NOP,0,1},
      '{1,0,1,32'h10000000,32'h0,0, 1,0,32'h0,NOP,0,1},
      '{1,0,1,32'h10000004,32'h4,0, 1,1,32'h0,32'h10000000,1,1},
      '{1,0,1,32'h10000008,32'h8,0, 1,1,32'h0,32'h10000000,2,1},
      '{1,0,1,32'h1000000C,32'hC,0, 1,1,32'h0,32'h10000000,3,1},
      '{1,0,1,32'h10000010,32'h10,0,1,1,32'h0,32'h10000000,4,0},
      '{1,0,1,32'h10000010,32'h10,1,1,1,32'h0,32'h10000000,4,0},
      '{1,0,0,32'h0,32'h0,1,        1,1,32'h4,32'h10000004,3,1},
      '{1,0,0,32'h0,32'h0,1,        1,1,32'h8,32'h10000008,2,1},
      '{1,0,0,32'h0,32'h0,1,        1,1,32'hC,32'h1000000C,1,1},
      '{1,0,0,32'h0,32'h0,0,        1,0,32'h0,NOP,0,1},
      '{1,0,1,32'h10000020,32'h20,0,1,0,32'h0,NOP,0,1},
      '{1,0,1,32'h10000024,32'h24,0,1,1,32'h20,32'h10000020,1,1},
      '{1,0,1,32'h10000028,32'h28,0,1,1,32'h20,32'h10000020,2,1},
      '{1,1,1,32'h10000040,32'h40,1,1,1,32'h20,32'h10000020,3,1},
      '{1,0,0,32'h0,32'h0,0,        1,0,32'h0,NOP,0,1}
    };

`ifndef FETCH_QUEUE_BYPASS_EN
    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].r, tbl[i].fl, tbl[i].ev, tbl[i].instr, tbl[i].pc, tbl[i].dr);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_deq_valid", i), bus.deq_valid, tbl[i].dv);
        check($sformatf("vec%0d_deq_instr", i), bus.deq_instr, tbl[i].einstr);
        check($sformatf("vec%0d_deq_pc", i), bus.deq_pc, tbl[i].epc);
        check($sformatf("vec%0d_deq_pcp4", i), bus.deq_pcp4, tbl[i].dv ? tbl[i].epc + 32'd4 : 32'd0);
        check($sformatf("vec%0d_deq_bp", i), bus.deq_bp, tbl[i].dv ? tbl[i].epc[2] : 1'b0);
        check($sformatf("vec%0d_deq_btarget", i), bus.deq_btarget,
              tbl[i].dv ? (tbl[i].epc ^ 32'h8000_0000) : 32'd0);
        check($sformatf("vec%0d_count", i), bus.count, tbl[i].cnt);
        check($sformatf("vec%0d_enq_ready", i), bus.enq_ready, tbl[i].er);
      end
    end
`else
    apply(0, 0, 0, 32'h0, 32'h0, 0);
    apply(0, 0, 0, 32'h0, 32'h0, 0);
    apply(1, 0, 1, 32'h00A00113, 32'h200, 1);
    check("byp_deq_valid", bus.deq_valid, 1'b1);
    check("byp_deq_pc", bus.deq_pc, 32'h200);
    check("byp_deq_instr", bus.deq_instr, 32'h00A00113);
    check("byp_count_same", bus.count, 0);
    apply(1, 0, 0, 32'h0, 32'h0, 0);
    check("byp_count_next", bus.count, 0);
    check("byp_deq_valid_next", bus.deq_valid, 1'b0);
    apply(1, 0, 1, 32'h00B00193, 32'h204, 0);
    check("byp_hold_pc", bus.deq_pc, 32'h204);
    apply(1, 0, 0, 32'h0, 32'h0, 0);
    check("byp_hold_count", bus.count, 1);
    check("byp_hold_stored_pc", bus.deq_pc, 32'h204);
`endif

    // Steady state at count 2 with enqueue and dequeue every cycle across pointer wrap.
    apply(0, 0, 0, 32'h0, 32'h0, 0);
    apply(1, 0, 1, 32'h300, 32'h300, 0);
    apply(1, 0, 1, 32'h304, 32'h304, 0);
    for (int i = 0; i < 10; i++) begin
      apply(1, 0, 1, 32'h308 + 4 * i, 32'h308 + 4 * i, 1);
      check($sformatf("wrap%0d_count", i), bus.count, 2);
      check($sformatf("wrap%0d_deq_pc", i), bus.deq_pc, 32'h300 + 4 * i);
      check($sformatf("wrap%0d_enq_ready", i), bus.enq_ready, 1'b1);
    end

    for (int i = 0; i < 400; i++) begin
      automatic logic [31:0] pc = {$urandom()} & 32'hFFFF_FFFC;
      apply($urandom_range(0, 63) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
            $urandom(), pc, $urandom_range(0, 2) == 0);
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling instruction buffer between the fetch stage and the decode stage.
- Holds fetched instruction packets: instruction, PC, PC+4, prediction bit, predicted target.
- Lets fetch run ahead of decode, and holds packets while decode is frozen on a data-cache stall.
- On a branch mispredict it discards every buffered packet in one cycle, so no wrong-path instruction reaches decode.

Parameters:
- DEPTH, 4, number of packet entries; must be a power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  input  1  global clock.
- rst_n  input  1  reset; synchronous, active-low, sampled on posedge clk.
- flush  input  1  mispredict flush; empties the queue this cycle.
- enq_valid  input  1  fetch presents a real (non-bubble) packet.
- enq_ready  output  1  queue can accept a packet this cycle.
- enq_instr  input  32  fetched instruction word.
- enq_pc  input  32  address of the instruction.
- enq_pcp4  input  32  address + 4.
- enq_bp  input  1  1 = fetch predicted taken.
- enq_btarget  input  32  predicted branch target.
- deq_valid  output  1  head packet is valid.
- deq_ready  input  1  decode consumes the head packet this cycle (held low during mstall).
- deq_instr  output  32  head instruction; NOP 0x00000033 when deq_valid=0.
- deq_pc  output  32  head PC; 0 when empty.
- deq_pcp4  output  32  head PC+4; 0 when empty.
- deq_bp  output  1  head prediction bit; 0 when empty.
- deq_btarget  output  32  head target; 0 when empty.
- count  output  AW+1  number of valid entries, 0..DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH packets, plus head/tail pointers (AW bits, wrap modulo DEPTH) and an occupancy counter (AW+1 bits).
- Reset (rst_n=0 at posedge): pointers = 0, count = 0.
  - Outputs follow: deq_valid=0, deq_instr=0x00000033, other deq_* = 0, enq_ready=1.
  - Entry contents need not be cleared.
- enq_ready = (count != DEPTH); purely a function of registered state, with no combinational path from deq_ready.
- deq_valid = (count != 0).
- deq_* are driven combinationally from the entry at head. When empty, the NOP/zero values above are forced.
- Enqueue fires when enq_valid & enq_ready. The packet is written at tail and tail increments.
- Dequeue fires when deq_valid & deq_ready. Head increments.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged when both fire.
  - When full, an enqueue cannot fire, even if a dequeue fires the same cycle.
- Latency: an enqueued packet appears on deq_* the cycle after the enqueue (no bypass in the base build).
- Ordering: strict FIFO.
- flush=1:
  - At the next posedge, head = tail = 0 and count = 0.
  - Any enqueue or dequeue in the same cycle is discarded.
  - Outputs in the flush cycle itself still reflect pre-flush state.
- Reset has priority over flush. Reset mid-operation drops all contents.
- enq_valid while full: the packet is not accepted. Fetch is responsible for holding its PC; the queue takes no action.
- Pointer wrap: tail/head go DEPTH-1 → 0 with no special handling. Full vs empty is disambiguated by count only.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and enq_valid=1 with no flush, deq_* show the enq_* packet in the same cycle and deq_valid=1.
  - If deq_ready=1 as well, the packet is consumed directly: nothing is written and count stays 0.
  - If deq_ready=0, the packet is written normally.
  - This adds a combinational path from enq_* to deq_*.
- Undefined: no bypass; minimum latency is 1 cycle, as above.

Test Plan:
- Reset then idle: rst_n low 2 cycles, then high → deq_valid=0, deq_instr=0x00000033, count=0, enq_ready=1.
- Single packet: enq instr=0x00500093, pc=0x100, pcp4=0x104, bp=0, deq_ready=1 → next cycle deq_valid=1, deq_instr=0x00500093, deq_pc=0x100; the following cycle count=0.
- Fill and back-pressure: deq_ready=0, enqueue pc 0x0,0x4,0x8,0xC, then offer 0x10 → count=4, enq_ready=0, 0x10 not accepted. Then deq_ready=1 → pcs drain in order 0x0,0x4,0x8,0xC, and enq_ready=1 after the first dequeue.
- Simultaneous enq/deq with wrap: keep count=2 while streaming 10 packets with enq and deq both firing every cycle → count stays 2, PCs emerge in order across pointer wrap.
- Flush: count=3, assert flush with enq_valid=1 (pc 0x40) → next cycle count=0, deq_valid=0, and 0x40 never appears on deq_pc.
- Bypass (macro defined): empty queue, enq pc=0x200 with deq_ready=1 → deq_pc=0x200 and deq_valid=1 in the same cycle; next cycle count=0.
